nrs_sched_tx: RTL

Sequential NRS scheduler for the NB-IoT transmit chain. It derives the cell's frequency shift, `v_shift = N_cell_ID mod 6`, with a fixed-latency iterative reduction. It then walks every resource element of a subframe in order: symbol-major, subcarrier-minor, 14 × 12. For each RE it flags whether the RE carries an NRS pilot and gives that pilot's index into the pilot sequence buffer. It sits between the subframe timing logic and the RE mapper, and feeds the mapper through a valid/ready handshake.

---
 rtl/nrs_sched_tx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/nrs_sched_tx.sv
// nrs_sched_tx: NB-IoT NRS scheduler. Reduces N_cell_ID to v_shift = N_cell_ID mod 6, then walks a 14x12 subframe flagging NRS pilots.
// Optional macro NRS_PORT1_EN adds input ant_port, which selects the antenna-port-1 pilot offsets.
module nrs_sched_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       cell_id_vld,
    input  logic [8:0] N_cell_ID,
    input  logic       sf_start,
    input  logic       nrs_en,
`ifdef NRS_PORT1_EN
    input  logic       ant_port,
`endif
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] sym_idx,
    output logic [3:0] sc_idx,
    output logic       is_nrs,
    output logic [2:0] nrs_addr,
    output logic [2:0] v_shift,
    output logic       vs_rdy,
    output logic       sf_done,
    output logic       req_err
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_READY, S_RUN} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [8:0] r_rem;
    logic [2:0] r_step;
    logic       r_nrs_en;
    logic       r_out_valid;
    logic       r_is_nrs;
    logic       r_vs_rdy;
    logic       r_sf_done;
    logic       r_req_err;
    logic [3:0] r_sym;
    logic [3:0] r_sc;
    logic [2:0] r_nrs_addr;
    logic [2:0] r_v_shift;

    logic       w_hs;
    logic       w_last;
    logic       w_cid_ok;
    logic       w_sf_ok;
    logic       w_err;
    logic [8:0] w_sub;
    logic [8:0] w_rem_nxt;
    logic [3:0] w_sym_nxt;
    logic [3:0] w_sc_nxt;
    logic       w_en_nxt;
    logic       w_port_nxt;
    logic [3:0] w_off_a;
    logic [3:0] w_off_b;
    logic [3:0] w_off;
    logic       w_pilot;
    logic [2:0] w_addr;

    assign w_hs     = (r_state == S_RUN) && r_out_valid && out_ready;
    assign w_last   = (r_sym == 4'd13) && (r_sc == 4'd11);
    assign w_cid_ok = cell_id_vld && ((r_state == S_IDLE) || (r_state == S_READY));
    // A simultaneous cell_id_vld takes priority, so sf_start is dropped.
    assign w_sf_ok  = sf_start && (r_state == S_READY) && !cell_id_vld;
    assign w_err    = (cell_id_vld && !w_cid_ok) || (sf_start && !w_sf_ok);

    // Step k subtracts 384 >> k: 384, 192, 96, 48, 24, 12, 6.
    assign w_sub     = 9'd384 >> r_step;
    assign w_rem_nxt = (r_rem >= w_sub) ? (r_rem - w_sub) : r_rem;

    always_comb begin
        // NOTE: assigning a default before the case keeps this purely combinational (no latch).
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cid_ok) w_state_nxt = S_CALC;
            S_CALC:  if (r_step == 3'd6) w_state_nxt = S_READY;
            S_READY: begin
                if (w_cid_ok)     w_state_nxt = S_CALC;
                else if (w_sf_ok) w_state_nxt = S_RUN;
            end
            S_RUN:   if (w_hs && w_last) w_state_nxt = S_READY;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-high.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_sym_nxt = r_sym;
        w_sc_nxt  = r_sc;
        w_en_nxt  = r_nrs_en;
        if (w_sf_ok) begin
            w_sym_nxt = 4'd0;
            w_sc_nxt  = 4'd0;
            w_en_nxt  = nrs_en;
        end else if (w_hs) begin
            if (r_sc == 4'd11) begin
                w_sc_nxt  = 4'd0;
                w_sym_nxt = w_last ? 4'd0 : (r_sym + 4'd1);
            end else begin
                w_sc_nxt  = r_sc + 4'd1;
            end
        end
    end

`ifdef NRS_PORT1_EN
    logic r_ant_port;
    always_ff @(posedge clk) begin
        if (rst)          r_ant_port <= 1'b0;
        else if (w_sf_ok) r_ant_port <= ant_port;
    end
    assign w_port_nxt = w_sf_ok ? ant_port : r_ant_port;
`else
    assign w_port_nxt = 1'b0;
`endif

    // Pilot flags are computed for the next position so that the descriptor leaves a register.
    assign w_off_a = {1'b0, r_v_shift};
    assign w_off_b = (r_v_shift >= 3'd3) ? ({1'b0, r_v_shift} - 4'd3) : ({1'b0, r_v_shift} + 4'd3);

    always_comb begin
        w_off   = w_off_a;
        w_pilot = 1'b0;
        case (w_sym_nxt)
            4'd5, 4'd12: begin
                w_off   = w_port_nxt ? w_off_b : w_off_a;
                w_pilot = w_en_nxt;
            end
            4'd6, 4'd13: begin
                w_off   = w_port_nxt ? w_off_a : w_off_b;
                w_pilot = w_en_nxt;
            end
            default: w_pilot = 1'b0;
        endcase
        w_pilot = w_pilot && ((w_sc_nxt == w_off) || (w_sc_nxt == (w_off + 4'd6)));
        w_addr  = {(w_sym_nxt >= 4'd7), ((w_sym_nxt == 4'd6) || (w_sym_nxt == 4'd13)),
                   (w_sc_nxt >= 4'd6)} & {3{w_pilot}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem       <= '0;
            r_step      <= '0;
            r_nrs_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_is_nrs    <= 1'b0;
            r_vs_rdy    <= 1'b0;
            r_sf_done   <= 1'b0;
            r_req_err   <= 1'b0;
            r_sym       <= '0;
            r_sc        <= '0;
            r_nrs_addr  <= '0;
            r_v_shift   <= '0;
        end else begin
            r_sf_done   <= w_hs && w_last;
            r_req_err   <= w_err;
            r_out_valid <= (w_state_nxt == S_RUN);
            r_sym       <= w_sym_nxt;
            r_sc        <= w_sc_nxt;
            r_nrs_en    <= w_en_nxt;
            r_is_nrs    <= w_pilot;
            r_nrs_addr  <= w_addr;
            if (w_cid_ok) begin
                r_rem    <= N_cell_ID;
                r_step   <= '0;
                r_vs_rdy <= 1'b0;
            end else if (r_state == S_CALC) begin
                r_rem  <= w_rem_nxt;
                r_step <= r_step + 3'd1;
                if (r_step == 3'd6) begin
                    r_v_shift <= w_rem_nxt[2:0];
                    r_vs_rdy  <= 1'b1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sym_idx   = r_sym;
    assign sc_idx    = r_sc;
    assign is_nrs    = r_is_nrs;
    assign nrs_addr  = r_nrs_addr;
    assign v_shift   = r_v_shift;
    assign vs_rdy    = r_vs_rdy;
    assign sf_done   = r_sf_done;
    assign req_err   = r_req_err;

endmodule
